boundary_packer: RTL

- Sits directly downstream of the PE-array return path of the data processor.
- Collects the last-column boundary entries (t, v, f), one per valid cycle, and packs ENTRIES of them into one SRAM word.
- Pushes each word to the SRAM controller through a 2-deep output queue, so boundary rows can be spilled between S passes.
- Counts entries against the target T length and flushes the final partial word.

---
 rtl/boundary_packer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/boundary_packer.sv
// boundary_packer: collects last-column boundary entries {t, v, f} from the
// PE-array return path and packs ENTRIES of them into one SRAM word. Each
// completed word goes through a 2-deep queue to the SRAM controller. The
// block counts entries against the pass length and flushes the final
// partial word zero-padded.
//
// Optional feature: define BOUNDARY_PACKER_CHECKSUM_EN to add o_checksum,
// the running XOR of v ^ f over every accepted entry of the current pass.
//
// Handshake: an entry is taken on every clock edge where i_t_valid=1 while
// the block is in PACK. There is no back-pressure toward the PE array.
// Toward the SRAM side, the head word is popped on an edge where the queue
// is non-empty and i_sram_ready=1. That pop shows up as a one-cycle
// o_sram_send pulse with o_send_data, registered on that edge.
// The FSM state is held in the internal signal 'state', of type state_t.
module boundary_packer #(
  parameter int SRAM_WORD  = 96,
  parameter int VEF_BIT    = 14,
  parameter int T_SIZE_LOG = 12,
  parameter int ENTRIES    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [T_SIZE_LOG-1:0] i_T_size,
  input  logic                  i_t_valid,
  input  logic [1:0]            i_t,
  input  logic [VEF_BIT-1:0]    i_v,
  input  logic [VEF_BIT-1:0]    i_f,
  input  logic                  i_sram_ready,
  output logic                  o_sram_send,
  output logic [SRAM_WORD-1:0]  o_send_data,
  output logic                  o_done,
  output logic                  o_overflow
`ifdef BOUNDARY_PACKER_CHECKSUM_EN
  ,
  output logic [VEF_BIT-1:0]    o_checksum
`endif
);

  localparam int E_W    = 2 + 2 * VEF_BIT;
  localparam int LANE_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nx;

  logic [T_SIZE_LOG-1:0] t_size;
  logic [T_SIZE_LOG-1:0] count;
  logic [LANE_W-1:0]     lane;
  logic [SRAM_WORD-1:0]  word_q;
  logic [SRAM_WORD-1:0]  word_fill;
  logic [E_W-1:0]        entry;

  logic [SRAM_WORD-1:0]  q_data [2];
  logic [1:0]            q_cnt;
  logic [1:0]            q_cnt_nx;

  logic                  accept;
  logic                  last_entry;
  logic                  word_done;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Decode what happens on the coming edge. i_start overrides all of this
  // in the sequential blocks.
  always_comb begin
    entry      = {i_t, i_v, i_f};
    accept     = (state == PACK) && i_t_valid;
    last_entry = (({1'b0, count} + (T_SIZE_LOG+1)'(1)) == {1'b0, t_size});
    word_done  = accept && ((lane == LANE_W'(ENTRIES - 1)) || last_entry);
    pop        = (q_cnt != 2'd0) && i_sram_ready;
    // A full queue can still take a word when its head leaves on the same edge.
    push       = word_done && ((q_cnt != 2'd2) || pop);
    drop       = word_done && (q_cnt == 2'd2) && !pop;
  end

  // Merge the incoming entry into its lane of the partial word.
  always_comb begin
    word_fill = word_q;
    for (int k = 0; k < ENTRIES; k++) begin
      if (lane == LANE_W'(k)) begin
        word_fill[k*E_W +: E_W] = entry;
      end
    end
  end

  // Queue occupancy after this edge, ignoring i_start.
  always_comb begin
    q_cnt_nx = q_cnt;
    if (push && !pop) begin
      q_cnt_nx = q_cnt + 2'd1;
    end else if (!push && pop) begin
      q_cnt_nx = q_cnt - 2'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state. A zero-length pass skips straight to DONE.
  always_comb begin
    state_nx = state;
    if (i_start) begin
      state_nx = (i_T_size == '0) ? DONE : PACK;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        PACK:    if (accept && last_entry) state_nx = FLUSH;
        FLUSH:   if (q_cnt_nx == 2'd0) state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign o_done = (state == DONE);

  // Pass bookkeeping: length, entry count, lane pointer and partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_size <= '0;
      count  <= '0;
      lane   <= '0;
      word_q <= '0;
    end else if (i_start) begin
      t_size <= i_T_size;
      count  <= '0;
      lane   <= '0;
      word_q <= '0;
    end else if (accept) begin
      count <= count + T_SIZE_LOG'(1);
      if (word_done) begin
        lane   <= '0;
        word_q <= '0;
      end else begin
        lane   <= lane + LANE_W'(1);
        word_q <= word_fill;
      end
    end
  end

  // Two-entry output queue, with slot 0 as the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
      end
    end else if (i_start) begin
      q_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
      end
    end else begin
      q_cnt <= q_cnt_nx;
      if (push && !pop) begin
        q_data[q_cnt[0]] <= word_fill;
      end else if (!push && pop) begin
        q_data[0] <= q_data[1];
      end else if (push && pop) begin
        if (q_cnt == 2'd1) begin
          q_data[0] <= word_fill;
        end else begin
          q_data[0] <= q_data[1];
          q_data[1] <= word_fill;
        end
      end
    end
  end

  // Registered SRAM write strobe. The data holds between sends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sram_send <= 1'b0;
      o_send_data <= '0;
    end else if (i_start) begin
      o_sram_send <= 1'b0;
    end else begin
      o_sram_send <= pop;
      if (pop) begin
        o_send_data <= q_data[0];
      end
    end
  end

  // Sticky overflow flag, set when a completed word finds the queue full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow <= 1'b0;
    end else if (i_start) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end
  end

`ifdef BOUNDARY_PACKER_CHECKSUM_EN
  // Running XOR of v and f over the entries accepted in this pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_checksum <= '0;
    end else if (i_start) begin
      o_checksum <= '0;
    end else if (accept) begin
      o_checksum <= o_checksum ^ i_v ^ i_f;
    end
  end
`endif

endmodule
